// File: rtl/arb_pkg.sv
// Shared types for the CPU/VGA data-memory port arbiter.
// Owner tags steer read data; priority states select the favoured requester.
package arb_pkg;

  localparam int MAX_WAIT_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VGA  = 2'd2
  } owner_e;

  typedef enum logic {
    PRIO_CPU = 1'b0,
    PRIO_VGA = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU, VGA and memory-side signals of the shared data-memory port.
// slave = arbiter side; master = requesters plus memory.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic          vga_gnt;
  logic          vga_rvalid;
  logic [DW-1:0] vga_rdata;

  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rd,
    output cpu_gnt, cpu_rvalid, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata,
    output mem_we, mem_a, mem_wd
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rd,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata,
    input  mem_we, mem_a, mem_wd
  );

endinterface

// File: rtl/arb_starve_counter.sv
// Counts consecutive denied VGA request cycles; hit flags the edge where the count reaches MAX_WAIT.
// hit is combinational from the current request/grant; no backpressure of its own.
module arb_starve_counter
  import arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rstin,
  input  logic vga_req,
  input  logic vga_gnt,
  output logic hit
);

  localparam logic [MAX_WAIT_W-1:0] LAST = MAX_WAIT_W'(MAX_WAIT - 1);

  logic [MAX_WAIT_W-1:0] cnt;
  logic                  waiting;

  assign waiting = vga_req & ~vga_gnt;

  // Saturate rather than wrap so a stuck denial never re-arms the threshold.
  always_ff @(posedge clk or negedge rstin) begin
    if (!rstin) begin
      cnt <= '0;
    end else if (!waiting) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = waiting & (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester data-memory arbiter: CPU priority, VGA forced after MAX_WAIT denials; grants same cycle, read data 1 cycle later.
// Requesters hold req until granted; ARB_PERF_CNT_EN adds saturating stall counters.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rstin,
  mem_port_arbiter_if.slave   bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]         cpu_stall_cnt,
  output logic [15:0]         vga_stall_cnt
`endif
);

  arb_state_e    state, state_nxt;
  owner_e        tag, tag_nxt;
  logic          cpu_gnt_c, vga_gnt_c;
  logic          starve_hit;
  logic [AW-1:0] mem_a_c;
  logic [DW-1:0] mem_wd_c;

  arb_starve_counter #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk     (clk),
    .rstin   (rstin),
    .vga_req (bus.vga_req),
    .vga_gnt (vga_gnt_c),
    .hit     (starve_hit)
  );

  always_ff @(posedge clk or negedge rstin) begin
    if (!rstin) begin
      state <= PRIO_CPU;
      tag   <= OWN_NONE;
    end else begin
      state <= state_nxt;
      tag   <= tag_nxt;
    end
  end

  // Grants are qualified by rstin so every output is quiet while reset is held.
  always_comb begin
    cpu_gnt_c = 1'b0;
    vga_gnt_c = 1'b0;
    state_nxt = state;
    if (rstin) begin
      case (state)
        PRIO_CPU: begin
          cpu_gnt_c = bus.cpu_req;
          vga_gnt_c = bus.vga_req & ~bus.cpu_req;
          if (starve_hit) state_nxt = PRIO_VGA;
        end
        PRIO_VGA: begin
          vga_gnt_c = bus.vga_req;
          cpu_gnt_c = bus.cpu_req & ~bus.vga_req;
          if (vga_gnt_c || !bus.vga_req) state_nxt = PRIO_CPU;
        end
        default: state_nxt = PRIO_CPU;
      endcase
    end
  end

  always_comb begin
    tag_nxt  = OWN_NONE;
    mem_a_c  = '0;
    mem_wd_c = '0;
    if (cpu_gnt_c) begin
      mem_a_c  = bus.cpu_addr;
      mem_wd_c = bus.cpu_wdata;
      if (!bus.cpu_we) tag_nxt = OWN_CPU;
    end else if (vga_gnt_c) begin
      mem_a_c = bus.vga_addr;
      tag_nxt = OWN_VGA;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt_c;
  assign bus.vga_gnt    = vga_gnt_c;
  assign bus.mem_we     = cpu_gnt_c & bus.cpu_we;
  assign bus.mem_a      = mem_a_c;
  assign bus.mem_wd     = mem_wd_c;
  assign bus.cpu_rvalid = (tag == OWN_CPU);
  assign bus.vga_rvalid = (tag == OWN_VGA);
  assign bus.cpu_rdata  = (tag == OWN_CPU) ? bus.mem_rd : '0;
  assign bus.vga_rdata  = (tag == OWN_VGA) ? bus.mem_rd : '0;

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rstin) begin
    if (!rstin) begin
      cpu_stall_cnt <= '0;
      vga_stall_cnt <= '0;
    end else begin
      if (bus.cpu_req && !cpu_gnt_c && cpu_stall_cnt != 16'hFFFF)
        cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
      if (bus.vga_req && !vga_gnt_c && vga_stall_cnt != 16'hFFFF)
        vga_stall_cnt <= vga_stall_cnt + 16'd1;
    end
  end
`endif

endmodule
